// File: rtl/periph_rx_packetizer_if.sv
// Bus bundle between a peripheral receive path, periph_rx_packetizer and the host-side arbiter.
// The slave modport is the packetizer's view; master is the surrounding logic's view.
interface periph_rx_packetizer_if #(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned PW = $clog2(DEPTH) + 1;

   logic [28:0]   rx_data;
   logic          rx_wren;
   logic          rx_full;
   logic          rx_afull;
   logic [31:0]   pkt_data;
   logic          pkt_valid;
   logic          pkt_ready;
   logic [PW-1:0] fill_level;
   logic          ovf_sticky;
   logic          ovf_clr;
   logic [15:0]   ovf_count;

   modport slave (
      input  rx_data, rx_wren, pkt_ready, ovf_clr,
      output rx_full, rx_afull, pkt_data, pkt_valid, fill_level, ovf_sticky, ovf_count
   );

   modport master (
      output rx_data, rx_wren, pkt_ready, ovf_clr,
      input  rx_full, rx_afull, pkt_data, pkt_valid, fill_level, ovf_sticky, ovf_count
   );
endinterface

// File: rtl/periph_rx_packetizer.sv
// Peripheral receive FIFO: buffers 29-bit words and emits {PERIPH_ADDR, word} packets (FWFT).
// Define PERIPH_RX_OVF_COUNT_EN to build the saturating 16-bit dropped-push counter.
module periph_rx_packetizer #(
   parameter logic [2:0]  PERIPH_ADDR  = 3'd0,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AFULL_THRESH = 12
) (
   input logic                   clk,
   input logic                   rst,
   periph_rx_packetizer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] DepthW = PW'(DEPTH);
   localparam logic [PW-1:0] AfullW = PW'(AFULL_THRESH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] fill;
   logic          full;
   logic          push;
   logic          pop;
   logic          ovf;
   logic          ovf_sticky_q, ovf_sticky_d;
   logic [28:0]   mem_q [DEPTH];

   // Full/empty come only from registered pointers, so the extra MSB separates the two.
   always_comb begin
      fill     = wr_ptr_q - rd_ptr_q;
      full     = (fill == DepthW);
      push     = bus.rx_wren & ~full;
      pop      = (fill != '0) & bus.pkt_ready;
      ovf      = bus.rx_wren & full;
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
   end

   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      if (ovf) begin
         ovf_sticky_d = 1'b1;
      end else if (bus.ovf_clr) begin
         ovf_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_sticky_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   // Storage needs no reset: nothing is visible until the write pointer moves past it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.rx_data;
      end
   end

   always_comb begin
      bus.pkt_data   = {PERIPH_ADDR, mem_q[rd_ptr_q[AW-1:0]]};
      bus.pkt_valid  = (fill != '0);
      bus.fill_level = fill;
      bus.rx_full    = full;
      bus.rx_afull   = (fill >= AfullW);
      bus.ovf_sticky = ovf_sticky_q;
   end

`ifdef PERIPH_RX_OVF_COUNT_EN
   logic [15:0] ovf_count_q, ovf_count_d;

   // An overflow in the same cycle as a clear restarts the count at one.
   always_comb begin
      ovf_count_d = ovf_count_q;
      if (ovf) begin
         if (bus.ovf_clr) begin
            ovf_count_d = 16'd1;
         end else if (ovf_count_q != 16'hFFFF) begin
            ovf_count_d = ovf_count_q + 16'd1;
         end
      end else if (bus.ovf_clr) begin
         ovf_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_count_q <= '0;
      end else begin
         ovf_count_q <= ovf_count_d;
      end
   end

   assign bus.ovf_count = ovf_count_q;
`else
   assign bus.ovf_count = 16'h0;
`endif
endmodule

// File: tb/tb_periph_rx_packetizer.sv
// Directed bench for periph_rx_packetizer with a queue scoreboard of expected packets.
module tb_periph_rx_packetizer;
   localparam int unsigned DEPTH = 16;
`ifdef PERIPH_RX_OVF_COUNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [31:0] exp_q [$];
   bit   m_sticky = 1'b0;
   int   m_count  = 0;

   always #5 clk = ~clk;

   periph_rx_packetizer_if #(.DEPTH(DEPTH)) bus ();

   periph_rx_packetizer #(
      .PERIPH_ADDR (3'd2),
      .DEPTH       (DEPTH),
      .AFULL_THRESH(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Entered and left at a falling edge; drives one cycle of inputs and updates the model.
   task automatic cycle(input logic wren, input logic [28:0] d, input logic rdy, input logic clr);
      int sz;
      sz = exp_q.size();
      bus.rx_wren   = wren;
      bus.rx_data   = d;
      bus.pkt_ready = rdy;
      bus.ovf_clr   = clr;
      chk("pkt_valid", 32'(bus.pkt_valid), 32'(sz != 0));
      if (rdy && sz != 0) chk("pkt_data", bus.pkt_data, exp_q.pop_front());
      if (wren && sz < DEPTH) exp_q.push_back({3'd2, d});
      if (wren && sz == DEPTH) begin
         m_sticky = 1'b1;
         m_count  = clr ? 1 : ((m_count == 65535) ? 65535 : m_count + 1);
      end else if (clr) begin
         m_sticky = 1'b0;
         m_count  = 0;
      end
      @(posedge clk);
      @(negedge clk);
      bus.rx_wren = 1'b0;
      bus.ovf_clr = 1'b0;
      chk("fill_level", 32'(bus.fill_level), 32'(exp_q.size()));
      chk("rx_full", 32'(bus.rx_full), 32'(exp_q.size() == DEPTH));
      chk("rx_afull", 32'(bus.rx_afull), 32'(exp_q.size() >= 12));
      chk("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
      chk("ovf_count", 32'(bus.ovf_count), CntEn ? 32'(m_count) : 32'd0);
   endtask

   task automatic drain();
      while (exp_q.size() != 0) cycle(1'b0, 29'h0, 1'b1, 1'b0);
      cycle(1'b0, 29'h0, 1'b1, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.rx_wren   = 1'b0;
      bus.rx_data   = '0;
      bus.pkt_ready = 1'b0;
      bus.ovf_clr   = 1'b0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.pkt_valid), 32'd0);
      chk("rst_fill", 32'(bus.fill_level), 32'd0);
      chk("rst_full", 32'(bus.rx_full), 32'd0);
      chk("rst_afull", 32'(bus.rx_afull), 32'd0);
      chk("rst_sticky", 32'(bus.ovf_sticky), 32'd0);
      chk("rst_count", 32'(bus.ovf_count), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Single word, held with ready low
      cycle(1'b1, 29'h0AB, 1'b0, 1'b0);
      chk("first_valid", 32'(bus.pkt_valid), 32'd1);
      chk("first_data", bus.pkt_data, 32'h4000_00AB);
      cycle(1'b0, 29'h0, 1'b0, 1'b0);
      chk("hold_data", bus.pkt_data, 32'h4000_00AB);
      drain();

      // Fill to capacity, overflow once, drain in order
      for (int i = 1; i <= 16; i++) cycle(1'b1, 29'(i), 1'b0, 1'b0);
      chk("fill16_full", 32'(bus.rx_full), 32'd1);
      chk("fill16_afull", 32'(bus.rx_afull), 32'd1);
      chk("fill16_level", 32'(bus.fill_level), 32'd16);
      cycle(1'b1, 29'd99, 1'b0, 1'b0);
      chk("drop99_sticky", 32'(bus.ovf_sticky), 32'd1);
      drain();
      cycle(1'b0, 29'h0, 1'b0, 1'b1);

      // Streaming through pointer wrap
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, 29'(i), 1'b1, 1'b0);
         chk("stream_fill", 32'(bus.fill_level), 32'd1);
      end
      drain();

      // Push and pop together while full
      for (int i = 0; i < 16; i++) cycle(1'b1, 29'(100 + i), 1'b0, 1'b0);
      cycle(1'b1, 29'h1FF, 1'b1, 1'b0);
      chk("fullpp_level", 32'(bus.fill_level), 32'd15);
      chk("fullpp_sticky", 32'(bus.ovf_sticky), 32'd1);
      chk("fullpp_count", 32'(bus.ovf_count), CntEn ? 32'd1 : 32'd0);
      drain();
      cycle(1'b0, 29'h0, 1'b0, 1'b1);

      // Counter saturation and clear interaction
      for (int i = 0; i < 16; i++) cycle(1'b1, 29'(200 + i), 1'b0, 1'b0);
`ifdef PERIPH_RX_OVF_COUNT_EN
      for (int i = 0; i < 70000; i++) cycle(1'b1, 29'h5, 1'b0, 1'b0);
      chk("sat_count", 32'(bus.ovf_count), 32'h0000_FFFF);
`else
      for (int i = 0; i < 3; i++) cycle(1'b1, 29'h5, 1'b0, 1'b0);
`endif
      cycle(1'b0, 29'h0, 1'b0, 1'b1);
      chk("clr_count", 32'(bus.ovf_count), 32'd0);
      chk("clr_sticky", 32'(bus.ovf_sticky), 32'd0);
      cycle(1'b1, 29'h6, 1'b0, 1'b1);
      chk("ovfclr_sticky", 32'(bus.ovf_sticky), 32'd1);
      chk("ovfclr_count", 32'(bus.ovf_count), CntEn ? 32'd1 : 32'd0);
      drain();

      // Asynchronous reset with data stored
      for (int i = 0; i < 5; i++) cycle(1'b1, 29'(300 + i), 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(bus.pkt_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_valid", 32'(bus.pkt_valid), 32'd0);
      chk("async_fill", 32'(bus.fill_level), 32'd0);
      chk("async_full", 32'(bus.rx_full), 32'd0);
      chk("async_sticky", 32'(bus.ovf_sticky), 32'd0);
      exp_q.delete();
      m_sticky = 1'b0;
      m_count  = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      cycle(1'b1, 29'h7, 1'b0, 1'b0);
      chk("post_rst_data", bus.pkt_data, 32'h4000_0007);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
